// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared state encoding, AHB encodings and the transfer legality check for the bridge
package ahb2apb_pkg;
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  // APB is word-wide: anything wider than a word, or not naturally aligned, cannot be forwarded
  function automatic logic illegal_xfer(input logic [1:0] addr, input logic [2:0] size);
    return size > HSIZE_WORD || (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus without PREADY/PSLVERR, every transfer is one SETUP plus one ACCESS cycle
interface apb_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  modport apb_m (output PADDR, PWDATA, PWRITE, PSEL, PENABLE, input PRDATA);
  modport apb_s (input PADDR, PWDATA, PWRITE, PSEL, PENABLE, output PRDATA);
endinterface

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-lite slave turning each single transfer into one SETUP/ACCESS APB transfer
module ahb2apb_bridge
  import ahb2apb_pkg::*;
#(
  parameter logic [31:0] PADDR_MASK  = 32'h0000_FFFF,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  apb_if.apb_m        apbif
);
  state_t state, nxt, start;
  logic accept;
  // HREADYOUT is high exactly in the states able to take a new address phase
  assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && HREADYOUT;
  assign start  = (CHECK_ALIGN && illegal_xfer(HADDR[1:0], HSIZE)) ? ERR1 : HWRITE ? WDATA : SETUP;
  assign HRDATA = (state == ACCESS && !apbif.PWRITE) ? apbif.PRDATA : 32'h0;
  // next-state: accepting states branch on the new transfer, the rest walk a fixed sequence
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE, ACCESS, ERR2: nxt = accept ? start : IDLE;
      WDATA:              nxt = SETUP;
      SETUP:              nxt = ACCESS;
      ERR1:               nxt = ERR2;
      default:            nxt = IDLE;
    endcase
  end
  // state plus registered outputs decoded from the next state; APB address/data held between transfers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state         <= IDLE;
      HREADYOUT     <= 1'b1;
      HRESP         <= HRESP_OKAY;
      apbif.PSEL    <= 1'b0;
      apbif.PENABLE <= 1'b0;
      apbif.PWRITE  <= 1'b0;
      apbif.PADDR   <= 32'h0;
      apbif.PWDATA  <= 32'h0;
    end else begin
      state         <= nxt;
      HREADYOUT     <= nxt == IDLE || nxt == ACCESS || nxt == ERR2;
      HRESP         <= (nxt == ERR1 || nxt == ERR2) ? HRESP_ERROR : HRESP_OKAY;
      apbif.PSEL    <= nxt == SETUP || nxt == ACCESS;
      apbif.PENABLE <= nxt == ACCESS;
      if (accept && start != ERR1) begin
        apbif.PADDR  <= HADDR & PADDR_MASK;
        apbif.PWRITE <= HWRITE;
      end
      if (state == WDATA) apbif.PWDATA <= HWDATA;
    end
  end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: randomized and directed AHB traffic checked by a queue-based scoreboard
module tb_ahb2apb_bridge;
  import ahb2apb_pkg::*;
  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel1 = 1'b0, sel2 = 1'b0, hwrite = 1'b0, stall = 1'b0;
  logic [31:0] haddr = 32'h0, hwdata = 32'h0;
  logic [1:0] htrans = HTRANS_IDLE;
  logic [2:0] hsize = HSIZE_WORD;
  logic hready1, hreadyout1, hresp1, hready2, hreadyout2, hresp2;
  logic [31:0] hrdata1, hrdata2;
  logic [31:0] mem1 [16];
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  exp_t q[$];
  apb_if a1();
  apb_if a2();
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign hready1 = stall ? 1'b0 : hreadyout1;
  assign hready2 = hreadyout2;
  ahb2apb_bridge dut (
    .CLK(clk), .nRST(rst_n), .HSEL(sel1), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready1), .HREADYOUT(hreadyout1), .HRESP(hresp1),
    .HRDATA(hrdata1), .apbif(a1)
  );
  ahb2apb_bridge #(.CHECK_ALIGN(1'b0)) dut_na (
    .CLK(clk), .nRST(rst_n), .HSEL(sel2), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready2), .HREADYOUT(hreadyout2), .HRESP(hresp2),
    .HRDATA(hrdata2), .apbif(a2)
  );
  function automatic logic [31:0] init_val(input int i);
    return (i == 13) ? 32'hDEAD_BEEF : 32'h1111_1111 * (i + 1);
  endfunction
  // peripheral behind dut: 16-word memory decoded on PADDR[5:2]
  assign a1.PRDATA = mem1[a1.PADDR[5:2]];
  assign a2.PRDATA = 32'hC0DE_0000 ^ a2.PADDR;
  always @(posedge clk) begin
    if (cyc == 0) for (int i = 0; i < 16; i++) mem1[i] <= init_val(i);
    else if (a1.PSEL && a1.PENABLE && a1.PWRITE) mem1[a1.PADDR[5:2]] <= a1.PWDATA;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // reference rule: a transfer is forwarded only if it fits in a word and is naturally aligned
  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] sz);
    return (sz > 3'd2) || ((addr % (32'd1 << sz)) != 0);
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // present one NONSEQ transfer, wait for it to be taken, then predict its completion
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
    exp_t e;
    logic ok;
    int n = 0;
    sel1 = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = sz;
    do begin
      @(negedge clk);
      ok = hready1;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    #1;
    if (!ok) begin
      chk("accept_timeout", 32'(ok), 32'd1);
    end else begin
      e.err   = model_err(addr, sz);
      e.wr    = wr;
      e.addr  = addr & 32'h0000_FFFF;
      e.wdata = wd;
      e.due   = cyc + ((!e.err && wr) ? 2 : 1);
      q.push_back(e);
      if (wr) hwdata = wd;
    end
    sel1 = 1'b0; htrans = HTRANS_IDLE;
  endtask
  // monitor: pops the prediction whenever the bridge completes a transfer on either response path
  initial begin
    exp_t e;
    logic [31:0] ref_mem [16];
    logic p_psel = 1'b0, p_pen = 1'b0, p_hro = 1'b1, p_resp = 1'b0, p_pwr = 1'b0;
    logic [31:0] p_paddr = 32'h0, p_pwdata = 32'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((a1.PSEL && a1.PENABLE) || (hresp1 && hreadyout1)) begin
          if (q.size() == 0) begin
            chk("spurious_completion", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("hresp", 32'(hresp1), 32'(e.err));
            chk("hreadyout_done", 32'(hreadyout1), 32'd1);
            if (e.err) begin
              chk("err1_hreadyout", 32'(p_hro), 32'd0);
              chk("err1_hresp", 32'(p_resp), 32'd1);
              chk("err_hrdata", hrdata1, 32'h0);
            end else begin
              chk("paddr", a1.PADDR, e.addr);
              chk("pwrite", 32'(a1.PWRITE), 32'(e.wr));
              chk("setup_psel", 32'(p_psel), 32'd1);
              chk("setup_penable", 32'(p_pen), 32'd0);
              chk("setup_hreadyout", 32'(p_hro), 32'd0);
              chk("setup_paddr", p_paddr, e.addr);
              chk("setup_pwrite", 32'(p_pwr), 32'(e.wr));
              if (e.wr) begin
                chk("pwdata", a1.PWDATA, e.wdata);
                chk("setup_pwdata", p_pwdata, e.wdata);
                chk("write_hrdata", hrdata1, 32'h0);
                ref_mem[e.addr[5:2]] = e.wdata;
              end else begin
                chk("hrdata", hrdata1, ref_mem[e.addr[5:2]]);
              end
            end
          end
        end else begin
          chk("hrdata_zero", hrdata1, 32'h0);
          if (q.size() != 0 && cyc > q[0].due) begin
            chk("missing_completion", cyc, q[0].due);
            void'(q.pop_front());
          end
        end
        chk("psel_in_error", 32'(a1.PSEL && hresp1), 32'd0);
      end
      p_psel = a1.PSEL; p_pen = a1.PENABLE; p_hro = hreadyout1; p_resp = hresp1;
      p_pwr = a1.PWRITE; p_paddr = a1.PADDR; p_pwdata = a1.PWDATA;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout", 32'(hreadyout1), 32'd1);
    chk("rst_hresp", 32'(hresp1), 32'd0);
    chk("rst_psel", 32'(a1.PSEL), 32'd0);
    chk("rst_penable", 32'(a1.PENABLE), 32'd0);
    chk("rst_paddr", a1.PADDR, 32'h0);
    chk("rst_pwdata", a1.PWDATA, 32'h0);
    chk("rst_hrdata", hrdata1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    sel1 = 1'b1; htrans = HTRANS_BUSY;
    repeat (3) begin
      @(negedge clk);
      chk("busy_hreadyout", 32'(hreadyout1), 32'd1);
      chk("busy_psel", 32'(a1.PSEL), 32'd0);
    end
    @(posedge clk); #1;
    htrans = HTRANS_NONSEQ; stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hreadyout", 32'(hreadyout1), 32'd1);
      chk("stall_psel", 32'(a1.PSEL), 32'd0);
    end
    @(posedge clk); #1;
    sel1 = 1'b0; htrans = HTRANS_IDLE; stall = 1'b0;
    idle(2);
    issue(1'b0, 32'h8000_1234, HSIZE_WORD, 32'h0);
    idle(3);
    issue(1'b1, 32'h0000_0010, HSIZE_WORD, 32'hA5A5_0001);
    @(negedge clk);
    chk("wdata_hreadyout", 32'(hreadyout1), 32'd0);
    chk("wdata_psel", 32'(a1.PSEL), 32'd0);
    idle(4);
    issue(1'b1, 32'h0000_0010, HSIZE_WORD, 32'h1234_5678);
    issue(1'b0, 32'h0000_0010, HSIZE_WORD, 32'h0);
    issue(1'b0, 32'hFFFF_0013, HSIZE_BYTE, 32'h0);
    issue(1'b1, 32'h0000_0006, HSIZE_HALF, 32'h0BAD_F00D);
    idle(4);
    issue(1'b0, 32'h0000_0002, HSIZE_WORD, 32'h0);
    idle(3);
    issue(1'b1, 32'h0000_0003, HSIZE_HALF, 32'h0);
    issue(1'b0, 32'h0000_0004, 3'd3, 32'h0);
    issue(1'b0, 32'h0000_0004, HSIZE_WORD, 32'h0);
    idle(4);
    sel2 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h2; hsize = HSIZE_WORD; hwrite = 1'b0;
    @(posedge clk); #1;
    sel2 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("na_setup_psel", 32'(a2.PSEL), 32'd1);
    chk("na_setup_penable", 32'(a2.PENABLE), 32'd0);
    chk("na_setup_hresp", 32'(hresp2), 32'd0);
    @(negedge clk);
    chk("na_access_penable", 32'(a2.PENABLE), 32'd1);
    chk("na_paddr", a2.PADDR, 32'h2);
    chk("na_hrdata", hrdata2, 32'hC0DE_0002);
    chk("na_hresp", 32'(hresp2), 32'd0);
    chk("na_hreadyout", 32'(hreadyout2), 32'd1);
    idle(2);
    issue(1'b1, 32'h0000_0020, HSIZE_WORD, 32'h7777_0000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_psel", 32'(a1.PSEL), 32'd0);
    chk("midrst_penable", 32'(a1.PENABLE), 32'd0);
    chk("midrst_hreadyout", 32'(hreadyout1), 32'd1);
    chk("midrst_pwrite", 32'(a1.PWRITE), 32'd0);
    chk("midrst_pwdata", a1.PWDATA, 32'h0);
    idle(1);
    issue(1'b0, 32'h0000_0020, HSIZE_WORD, 32'h0);
    idle(3);
    for (int i = 0; i < 60; i++) begin
      logic w;
      logic [2:0] sz;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      issue(w, a, sz, $urandom);
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) begin sel1 = 1'b1; htrans = HTRANS_BUSY; end
        else begin sel1 = 1'b0; htrans = HTRANS_NONSEQ; end
        @(posedge clk); #1;
        sel1 = 1'b0; htrans = HTRANS_IDLE;
      end
    end
    idle(6);
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
